// File: rtl/sd_nios2_attempt_sd_cmd_rx.sv
// SD CMD-line response receiver (48/136-bit frames) with an Avalon-MM register window.
// Define SD_CMD_RX_CRC_EN to build the CRC7 check for 48-bit responses.
module sd_nios2_attempt_sd_cmd_rx #(
    parameter int TIMEOUT_EDGES = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sd_clk_in,
    input  logic        sd_cmd_in,
    output logic        irq
);

    localparam int EDGE_W = $clog2(TIMEOUT_EDGES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RECV, DONE} state_t;

    state_t              state_reg;
    logic [135:0]        resp_reg;
    logic [EDGE_W-1:0]   edge_cnt_reg;
    logic [7:0]          bit_cnt_reg;
    logic                done_reg, crc_err_reg, end_err_reg, timeout_reg;
    logic                long_reg, irq_en_reg;

    logic [SYNC_STAGES-1:0] clk_sync_reg, clk_sync_next;
    logic [SYNC_STAGES-1:0] cmd_sync_reg, cmd_sync_next;
    logic                   clk_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign clk_sync_next[gi] = sd_clk_in;
                assign cmd_sync_next[gi] = sd_cmd_in;
            end else begin : g_chain
                assign clk_sync_next[gi] = clk_sync_reg[gi-1];
                assign cmd_sync_next[gi] = cmd_sync_reg[gi-1];
            end
        end
    endgenerate

    // Bus idles high, so the chain resets to 1 to avoid a false start bit or edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg <= '1;
            cmd_sync_reg <= '1;
            clk_prev_reg <= 1'b1;
        end else begin
            clk_sync_reg <= clk_sync_next;
            cmd_sync_reg <= cmd_sync_next;
            clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
        end
    end

    logic sync_cmd, rise;
    assign sync_cmd = cmd_sync_reg[SYNC_STAGES-1];
    assign rise     = clk_sync_reg[SYNC_STAGES-1] & ~clk_prev_reg;

    logic wr_ctrl, do_abort, do_arm, last_bit;
    assign wr_ctrl  = chipselect & ~write_n & (address == 3'd0);
    assign do_abort = wr_ctrl & writedata[3];
    assign do_arm   = wr_ctrl & writedata[0] & ~writedata[3];
    assign last_bit = (bit_cnt_reg == (long_reg ? 8'd135 : 8'd47));

    logic crc_mismatch;
    logic crc_checked;
`ifdef SD_CMD_RX_CRC_EN
    logic [6:0] crc_reg;
    logic       crc_fb;
    assign crc_fb       = sync_cmd ^ crc_reg[6];
    assign crc_checked  = 1'b1;
    // After 47 bits the received CRC field (bits 41..47) sits in resp[6:0].
    assign crc_mismatch = ~long_reg & (crc_reg != resp_reg[6:0]);

    always_ff @(posedge clk) begin
        if (reset || do_arm) begin
            crc_reg <= 7'd0;
        end else if (!do_abort && state_reg == RECV && rise && !long_reg && bit_cnt_reg < 8'd40) begin
            crc_reg <= {crc_reg[5:3], crc_reg[2] ^ crc_fb, crc_reg[1:0], crc_fb};
        end
    end
`else
    assign crc_checked  = 1'b0;
    assign crc_mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            resp_reg     <= '0;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            done_reg     <= 1'b0;
            crc_err_reg  <= 1'b0;
            end_err_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            long_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
        end else if (do_abort) begin
            state_reg  <= IDLE;
            irq_en_reg <= writedata[2];
        end else if (do_arm) begin
            state_reg    <= WAIT;
            resp_reg     <= '0;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            done_reg     <= 1'b0;
            crc_err_reg  <= 1'b0;
            end_err_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            long_reg     <= writedata[1];
            irq_en_reg   <= writedata[2];
        end else begin
            if (wr_ctrl) begin
                irq_en_reg <= writedata[2];
            end
            case (state_reg)
                WAIT: begin
                    if (rise) begin
                        edge_cnt_reg <= edge_cnt_reg + 1'b1;
                        if (!sync_cmd) begin
                            resp_reg    <= {resp_reg[134:0], 1'b0};
                            bit_cnt_reg <= 8'd1;
                            state_reg   <= RECV;
                        end else if (edge_cnt_reg == EDGE_W'(TIMEOUT_EDGES - 1)) begin
                            timeout_reg <= 1'b1;
                            done_reg    <= 1'b1;
                            state_reg   <= IDLE;
                        end
                    end
                end
                RECV: begin
                    if (rise) begin
                        resp_reg    <= {resp_reg[134:0], sync_cmd};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (last_bit) begin
                            end_err_reg <= ~sync_cmd;
                            crc_err_reg <= crc_mismatch;
                            done_reg    <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic busy;
    assign busy = (state_reg == WAIT) || (state_reg == RECV);
    assign irq  = done_reg & irq_en_reg;

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata = {24'd0, crc_checked, irq_en_reg, long_reg, timeout_reg,
                              end_err_reg, crc_err_reg, done_reg, busy};
            3'd1: readdata = resp_reg[31:0];
            3'd2: readdata = resp_reg[63:32];
            3'd3: readdata = resp_reg[95:64];
            3'd4: readdata = resp_reg[127:96];
            3'd5: readdata = {24'd0, resp_reg[135:128]};
            default: readdata = 32'd0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:4]};

endmodule
